// File: rtl/iter_muldiv_unit.sv
// iter_muldiv_unit: multi-cycle responder for the ALU start/ready handshake.
// Multiply is WIDTH-bit signed radix-2 Booth, divide is WIDTH-bit unsigned
// restoring; each takes WIDTH iterations with one operation in flight.
module iter_muldiv_unit #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               ready,
    output logic               div_by_zero,
    output logic [2*WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // One Booth iteration: add/subtract the sign-extended multiplier per the
    // {q[0], q_1} pair, then arithmetic-shift {acc, q, q_1} right by one.
    // The returned vector is already the shifted {acc, q, q_1}.
    function automatic logic [2*WIDTH+1:0] booth_step(
        input logic [WIDTH:0]   acc,
        input logic [WIDTH-1:0] q,
        input logic             q1,
        input logic [WIDTH-1:0] m
    );
        logic [WIDTH:0] m_ext;
        logic [WIDTH:0] sum;
        m_ext = {m[WIDTH-1], m};
        case ({q[0], q1})
            2'b01:   sum = acc + m_ext;
            2'b10:   sum = acc - m_ext;
            default: sum = acc;
        endcase
        return {sum[WIDTH], sum, q};
    endfunction

    // One restoring-division iteration: shift {rem, q} left, try subtracting
    // the divisor and keep the difference only when it does not go negative.
    // Returns {rem (WIDTH+1 bits), q (WIDTH bits)}.
    function automatic logic [2*WIDTH:0] restore_step(
        input logic [WIDTH-1:0] rem,
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH:0]   rem_sh;
        logic [WIDTH:0]   d_ext;
        logic [WIDTH:0]   rem_n;
        logic [WIDTH-1:0] q_n;
        rem_sh = {rem, q[WIDTH-1]};
        d_ext  = {1'b0, d};
        if (rem_sh >= d_ext) begin
            rem_n = rem_sh - d_ext;
            q_n   = {q[WIDTH-2:0], 1'b1};
        end else begin
            rem_n = rem_sh;
            q_n   = {q[WIDTH-2:0], 1'b0};
        end
        return {rem_n, q_n};
    endfunction

    // Architectural state. acc_q is the Booth accumulator for multiply and the
    // partial remainder for divide; only one is live at a time.
    state_e             state_q, state_d;
    logic               op_q, op_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               q1_q, q1_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic               dbz_q, dbz_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    // Per-iteration datapath results for both operations.
    logic [WIDTH:0]     acc_mul_s;
    logic [WIDTH-1:0]   q_mul_s;
    logic               q1_mul_s;
    logic [WIDTH:0]     rem_div_s;
    logic [WIDTH-1:0]   q_div_s;

    // Evaluate one multiply and one divide iteration from the current state.
    always_comb begin
        {acc_mul_s, q_mul_s, q1_mul_s} = booth_step(acc_q, q_q, q1_q, b_q);
        {rem_div_s, q_div_s}           = restore_step(acc_q[WIDTH-1:0], q_q, b_q);
    end

    // Next-state logic: operand capture, iteration, result publication.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        b_d      = b_q;
        acc_d    = acc_q;
        q_d      = q_q;
        q1_d     = q1_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        ready_d  = 1'b0;
        dbz_d    = dbz_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    b_d     = b;
                    acc_d   = {(WIDTH+1){1'b0}};
                    q_d     = a;
                    q1_d    = 1'b0;
                    cnt_d   = CNT_LOAD;
                    busy_d  = 1'b1;
                    dbz_d   = 1'b0;
                    state_d = S_CALC;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q - CNT_ONE;
                if (op_q) begin
                    acc_d = rem_div_s;
                    q_d   = q_div_s;
                end else begin
                    acc_d = acc_mul_s;
                    q_d   = q_mul_s;
                    q1_d  = q1_mul_s;
                end
                if (cnt_q == CNT_ONE) begin
                    if (op_q) begin
                        result_d = {q_div_s, rem_div_s[WIDTH-1:0]};
                        dbz_d    = (b_q == {WIDTH{1'b0}});
                    end else begin
                        result_d = {acc_mul_s[WIDTH-1:0], q_mul_s};
                        dbz_d    = 1'b0;
                    end
                    ready_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset that overrides any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= 1'b0;
            b_q      <= {WIDTH{1'b0}};
            acc_q    <= {(WIDTH+1){1'b0}};
            q_q      <= {WIDTH{1'b0}};
            q1_q     <= 1'b0;
            cnt_q    <= CNT_ZERO;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            dbz_q    <= 1'b0;
            result_q <= {(2*WIDTH){1'b0}};
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            q1_q     <= q1_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            dbz_q    <= dbz_d;
            result_q <= result_d;
        end
    end

    assign busy        = busy_q;
    assign ready       = ready_q;
    assign div_by_zero = dbz_q;
    assign result      = result_q;

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Self-checking bench for iter_muldiv_unit (WIDTH = 16).
module tb_iter_muldiv_unit;

    localparam int W = 16;

    logic           clk;
    logic           rst;
    logic           start;
    logic           op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           ready;
    logic           div_by_zero;
    logic [2*W-1:0] result;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2*W-1:0] res;
        logic           dbz;
    } exp_t;

    exp_t sb_q[$];

    iter_muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .ready       (ready),
        .div_by_zero (div_by_zero),
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arithmetic, no iteration.
    function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        logic signed [2*W-1:0] sx;
        logic signed [2*W-1:0] sy;
        if (o == 1'b0) begin
            sx = {{W{x[W-1]}}, x};
            sy = {{W{y[W-1]}}, y};
            e.res = sx * sy;
            e.dbz = 1'b0;
        end else if (y == '0) begin
            e.res = {16'hFFFF, x};
            e.dbz = 1'b1;
        end else begin
            e.res = {x / y, x % y};
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Drive a one-cycle start pulse (called just after a rising edge) and
    // record the expected outcome; returns just after the accepting edge.
    task automatic launch(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        op = o; a = x; b = y; start = 1'b1;
        sb_q.push_back(model(o, x, y));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || ready !== 1'b0 || div_by_zero !== 1'b0 || result !== '0) begin
            failures++;
            $display("FAIL reset_state got busy=%b ready=%b dbz=%b result=%h expected 0 0 0 0",
                     busy, ready, div_by_zero, result);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_mul();
        int n;
        bit got;
        exp_t e;
        launch(1'b0, 16'd3, 16'hFFFB);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy_calc got %b expected 1", busy);
        end
        n = 0; got = 0;
        while (!got && n < 40) begin
            @(posedge clk); #1; n++;
            if (ready) got = 1;
        end
        e = sb_q.pop_front();
        checks++;
        if (!got || n != 16) begin
            failures++;
            $display("FAIL basic_latency got %0d (seen=%0d) expected 16", n, got);
        end
        checks++;
        if (result !== e.res || result !== 32'hFFFF_FFF1) begin
            failures++;
            $display("FAIL basic_result got %h expected %h", result, 32'hFFFF_FFF1);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_after_done got busy=%b ready=%b expected 0 0", busy, ready);
        end
    endtask

    task automatic test_mul();
        logic [W-1:0] ta [8];
        logic [W-1:0] tb_ [8];
        int n;
        bit got;
        exp_t e;
        ta[0] = 16'h8000; tb_[0] = 16'h8000;
        ta[1] = 16'h7FFF; tb_[1] = 16'h7FFF;
        ta[2] = 16'h8000; tb_[2] = 16'h7FFF;
        ta[3] = 16'hFFFF; tb_[3] = 16'hFFFF;
        for (int i = 4; i < 8; i++) begin
            ta[i] = W'($urandom_range(0, 65535));
            tb_[i] = W'($urandom_range(0, 65535));
        end
        for (int i = 0; i < 8; i++) begin
            launch(1'b0, ta[i], tb_[i]);
            n = 0; got = 0;
            while (!got && n < 40) begin
                @(posedge clk); #1; n++;
                if (ready) got = 1;
            end
            e = sb_q.pop_front();
            checks++;
            if (!got || result !== e.res || div_by_zero !== 1'b0) begin
                failures++;
                $display("FAIL mul_%0d a=%h b=%h got %h dbz=%b expected %h dbz=0",
                         i, ta[i], tb_[i], result, div_by_zero, e.res);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (model(1'b0, 16'h8000, 16'h8000).res !== 32'h4000_0000 ||
            model(1'b0, 16'h7FFF, 16'h7FFF).res !== 32'h3FFF_0001) begin
            failures++;
            $display("FAIL mul_model_sanity reference model disagrees with known products");
        end
    endtask

    task automatic test_div();
        logic [W-1:0] ta [8];
        logic [W-1:0] tb_ [8];
        int n;
        bit got;
        exp_t e;
        ta[0] = 16'd100;  tb_[0] = 16'd7;
        ta[1] = 16'hFFFF; tb_[1] = 16'd1;
        ta[2] = 16'd5;    tb_[2] = 16'd9;
        ta[3] = 16'hFFFF; tb_[3] = 16'hFFFF;
        for (int i = 4; i < 8; i++) begin
            ta[i] = W'($urandom_range(0, 65535));
            tb_[i] = W'($urandom_range(1, 65535));
        end
        for (int i = 0; i < 8; i++) begin
            launch(1'b1, ta[i], tb_[i]);
            n = 0; got = 0;
            while (!got && n < 40) begin
                @(posedge clk); #1; n++;
                if (ready) got = 1;
            end
            e = sb_q.pop_front();
            checks++;
            if (!got || n != 16 || result !== e.res || div_by_zero !== 1'b0) begin
                failures++;
                $display("FAIL div_%0d a=%h b=%h got %h dbz=%b lat=%0d expected %h dbz=0 lat=16",
                         i, ta[i], tb_[i], result, div_by_zero, n, e.res);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_div_by_zero();
        int n;
        bit got;
        exp_t e;
        launch(1'b1, 16'd1234, 16'd0);
        n = 0; got = 0;
        while (!got && n < 40) begin
            @(posedge clk); #1; n++;
            if (ready) got = 1;
        end
        e = sb_q.pop_front();
        checks++;
        if (!got || result !== {16'hFFFF, 16'd1234} || div_by_zero !== 1'b1 || e.dbz !== 1'b1) begin
            failures++;
            $display("FAIL dbz_result got %h dbz=%b expected %h dbz=1",
                     result, div_by_zero, {16'hFFFF, 16'd1234});
        end
        @(posedge clk); #1;
        checks++;
        if (div_by_zero !== 1'b1 || result !== {16'hFFFF, 16'd1234}) begin
            failures++;
            $display("FAIL dbz_hold_idle got %h dbz=%b expected held values", result, div_by_zero);
        end
        launch(1'b1, 16'd10, 16'd3);
        checks++;
        if (div_by_zero !== 1'b0 || result !== {16'hFFFF, 16'd1234} || busy !== 1'b1) begin
            failures++;
            $display("FAIL dbz_clear_on_start got dbz=%b result=%h busy=%b expected 0 %h 1",
                     div_by_zero, result, busy, {16'hFFFF, 16'd1234});
        end
        n = 0; got = 0;
        while (!got && n < 40) begin
            @(posedge clk); #1; n++;
            if (ready) got = 1;
        end
        e = sb_q.pop_front();
        checks++;
        if (!got || result !== e.res || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL dbz_followup got %h dbz=%b expected %h dbz=0", result, div_by_zero, e.res);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_inputs();
        int pulses;
        int first_n;
        exp_t e;
        launch(1'b0, 16'd3, 16'd7);
        pulses = 0; first_n = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (ready) begin
                pulses++;
                if (pulses == 1) begin
                    first_n = n;
                    e = sb_q.pop_front();
                    checks++;
                    if (result !== e.res || result !== 32'd21 || div_by_zero !== 1'b0) begin
                        failures++;
                        $display("FAIL ignore_result got %h dbz=%b expected %h dbz=0",
                                 result, div_by_zero, e.res);
                    end
                end
            end
            if (n == 4) begin
                op = 1'b1; a = 16'hABCD; b = 16'd0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        checks++;
        if (pulses != 1 || first_n != 16) begin
            failures++;
            $display("FAIL ignore_pulses got %0d pulses first at %0d expected 1 at 16", pulses, first_n);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        int pos [4];
        int n;
        bit got;
        exp_t e;
        op = 1'b0; a = 16'd1000; b = 16'hFF00; start = 1'b1;
        for (int i = 0; i < 3; i++) sb_q.push_back(model(1'b0, 16'd1000, 16'hFF00));
        @(posedge clk); #1;
        pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (ready) begin
                if (pulses < 4) pos[pulses] = k;
                pulses++;
                e = sb_q.pop_front();
                checks++;
                if (result !== e.res) begin
                    failures++;
                    $display("FAIL b2b_result_%0d got %h expected %h", pulses, result, e.res);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (pulses != 2 || pos[0] != 16 || pos[1] != 34) begin
            failures++;
            $display("FAIL b2b_spacing got %0d pulses at %0d,%0d expected 2 at 16,34",
                     pulses, pos[0], pos[1]);
        end
        n = 0; got = 0;
        while (!got && n < 40) begin
            @(posedge clk); #1; n++;
            if (ready) got = 1;
        end
        checks++;
        if (!got || n != 12 || sb_q.size() != 1) begin
            failures++;
            $display("FAIL b2b_third got seen=%0d at %0d queue=%0d expected seen=1 at 12 queue=1",
                     got, n, sb_q.size());
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (result !== e.res) begin
                failures++;
                $display("FAIL b2b_third_result got %h expected %h", result, e.res);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_calc();
        int n;
        bit got;
        exp_t e;
        launch(1'b0, 16'h1234, 16'h5678);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb_q.pop_front());
        checks++;
        if (busy !== 1'b0 || ready !== 1'b0 || result !== '0 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid got busy=%b ready=%b result=%h dbz=%b expected 0 0 0 0",
                     busy, ready, result, div_by_zero);
        end
        launch(1'b1, 16'd50000, 16'd123);
        n = 0; got = 0;
        while (!got && n < 40) begin
            @(posedge clk); #1; n++;
            if (ready) got = 1;
        end
        e = sb_q.pop_front();
        checks++;
        if (!got || n != 16 || result !== e.res) begin
            failures++;
            $display("FAIL rst_mid_recover got %h lat=%0d expected %h lat=16", result, n, e.res);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic_mul();
        test_mul();
        test_div();
        test_div_by_zero();
        test_ignore_inputs();
        test_back_to_back();
        test_reset_mid_calc();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d leftover expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
